sca_sparse_list_encoder: RTL and testbench
==========================================

Name: sca_sparse_list_encoder

Overview:
- Producer side of the SCA fallback sparse-scheduler interface.
- Accepts a stream of (src, dst, weight) connection triplets for one tile and discards zero weights.
- Compacts the surviving entries into N_ROWS x N_COLS slots: a dense weight_data matrix plus an index_data matrix in the packed {enable, dst, src} format.
- Presents each completed frame to the sparse conv core with a valid/ready handshake and a per-frame address tag.

Parameters:
- DATA_W, 16, weight width (signed).
- N_ROWS, 4, slot rows.
- N_COLS, 4, slot columns. IN_SIZE = N_ROWS*N_COLS slots per frame.
- INDEX_ADDR_W, 10, packed index entry width. PACK_BITS = max(1, (INDEX_ADDR_W-1)/2).
- WEIGHT_ADDR_W, 12, frame address counter width.
- SKIP_ZERO, 1, 1 = drop zero-valued weights; 0 = store every entry.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  triplet valid.
- in_ready  out  1  encoder can accept a triplet.
- in_src  in  PACK_BITS  source activation index.
- in_dst  in  PACK_BITS  destination accumulator index.
- in_weight  in  DATA_W  signed weight.
- in_last  in  1  marks the final triplet of the frame.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer takes the frame.
- weight_data  out  DATA_W x [N_ROWS][N_COLS]  slot weights. Slot k = r*N_COLS+c.
- index_data  out  INDEX_ADDR_W x [N_ROWS][N_COLS]  packed entries.
- frame_count  out  clog2(IN_SIZE+1)  number of enabled slots.
- frame_overflow  out  1  one or more entries were dropped because all slots were full.
- frame_addr  out  WEIGHT_ADDR_W  frame sequence tag.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to S_FILL.
  - All slot weights and indexes = 0; frame_count = 0; frame_overflow = 0; frame_addr = 0; frame_valid = 0.
  - in_ready = 1 once rst_n deasserts.
  - Reset mid-frame discards the partial frame.
- Packed entry format:
  - bit INDEX_ADDR_W-1 = enable.
  - bits [2*PACK_BITS-1:PACK_BITS] = dst.
  - bits [PACK_BITS-1:0] = src.
  - All remaining bits = 0.
  - An unused slot is all-zero with weight 0.
- State S_FILL (in_ready=1, frame_valid=0), on each accepted triplet (in_valid && in_ready):
  - Entry is "kept" if SKIP_ZERO==0 or in_weight != 0.
  - Kept and count < IN_SIZE: write slot[count] = {1, in_dst, in_src} and in_weight; count++.
  - Kept and count == IN_SIZE: entry dropped; frame_overflow set (sticky for the frame).
  - Not kept: no slot change.
  - If in_last: go to S_HOLD next cycle, whether or not the last entry was kept or dropped.
- State S_HOLD (in_ready=0, frame_valid=1):
  - All frame outputs are stable while frame_valid=1 and frame_ready=0.
  - On frame_ready: next cycle clear all slots, count and frame_overflow; frame_addr++ (wraps modulo 2^WEIGHT_ADDR_W); return to S_FILL.
- Latency and throughput:
  - frame_valid rises exactly 1 cycle after the in_last handshake.
  - in_ready returns 1 exactly 1 cycle after the frame_ready handshake.
  - No input is accepted in the handshake cycle itself (no overlap; single buffer).
- Slot ordering: arrival order of kept entries. Duplicate (src, dst) pairs occupy separate slots; the consumer accumulates them.
- Empty frame: in_last with no kept entries gives a frame with frame_count=0 and all slots zero.
- in_src and in_dst are used verbatim at PACK_BITS width; no range checking.
- Inputs are ignored when in_valid=0. frame_ready is ignored when frame_valid=0.

Test Plan:
- Reset, then send triplets (1,2,+5), (3,0,0), (4,4,-7, last) → 1 cycle later frame_valid=1, frame_count=2, index_data[0][0]=0x221, weight_data[0][0]=5, index_data[0][1]=0x244, weight_data[0][1]=-7, all other slots 0, frame_addr=0.
- 20 nonzero triplets in one frame with last on #20 → frame_count=16, frame_overflow=1, slots hold entries 1-16. Next frame after frame_ready → frame_overflow=0, frame_addr=1.
- Hold frame_ready=0 for 10 cycles with in_valid=1 → in_ready=0 throughout, outputs unchanged. Assert frame_ready → in_ready=1 next cycle, all slots cleared.
- Single zero-weight triplet with last, SKIP_ZERO=1 → frame_count=0, all index_data=0. Same stimulus with SKIP_ZERO=0 → frame_count=1, slot 0 enable=1, weight 0.
- Assert rst_n low after 3 triplets mid-frame → all outputs 0 immediately. After release, a fresh 1-entry frame reports frame_count=1, frame_addr=0.
- 4096 back-to-back empty frames → frame_addr wraps from 4095 to 0.

Source files
------------

// File: rtl/sca_sparse_list_encoder.sv
// sca_sparse_list_encoder
//   Producer side of the SCA fallback sparse-scheduler interface. Collects a stream of
//   (src, dst, weight) triplets for one tile, optionally drops zero weights, and compacts
//   the survivors in arrival order into N_ROWS x N_COLS slots. A completed frame is held
//   for the sparse conv core behind a valid/ready handshake, tagged with a frame address.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready triplet handshake (in_ready only while filling)
//   in_src, in_dst    PACK_BITS-wide indices, packed verbatim
//   in_weight         signed DATA_W weight
//   in_last           final triplet of the frame
//   frame_valid/ready frame handshake (single buffer, no fill/hold overlap)
//   weight_data       per-slot weights, slot k = r*N_COLS + c
//   index_data        per-slot packed {enable, dst, src}; unused slots are all-zero
//   frame_count       number of enabled slots
//   frame_overflow    at least one kept entry was dropped because all slots were full
//   frame_addr        frame sequence tag, wraps modulo 2^WEIGHT_ADDR_W
module sca_sparse_list_encoder #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned N_ROWS        = 4,
  parameter int unsigned N_COLS        = 4,
  parameter int unsigned INDEX_ADDR_W  = 10,
  parameter int unsigned WEIGHT_ADDR_W = 12,
  parameter int unsigned SKIP_ZERO     = 1,
  localparam int unsigned IN_SIZE      = N_ROWS * N_COLS,
  localparam int unsigned PACK_BITS    = ((INDEX_ADDR_W - 1) / 2 > 1) ? (INDEX_ADDR_W - 1) / 2 : 1,
  localparam int unsigned CNT_W        = $clog2(IN_SIZE + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [PACK_BITS-1:0]                          in_src,
  input  logic [PACK_BITS-1:0]                          in_dst,
  input  logic [DATA_W-1:0]                             in_weight,
  input  logic                                          in_last,
  output logic                                          frame_valid,
  input  logic                                          frame_ready,
  output logic [N_ROWS-1:0][N_COLS-1:0][DATA_W-1:0]       weight_data,
  output logic [N_ROWS-1:0][N_COLS-1:0][INDEX_ADDR_W-1:0] index_data,
  output logic [CNT_W-1:0]                              frame_count,
  output logic                                          frame_overflow,
  output logic [WEIGHT_ADDR_W-1:0]                      frame_addr
);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e                                          r_state;
  logic [N_ROWS-1:0][N_COLS-1:0][DATA_W-1:0]       r_weight;
  logic [N_ROWS-1:0][N_COLS-1:0][INDEX_ADDR_W-1:0] r_index;
  logic [CNT_W-1:0]                                r_count;
  logic                                            r_overflow;
  logic [WEIGHT_ADDR_W-1:0]                        r_addr;

  logic                    w_accept;
  logic                    w_keep;
  logic                    w_full;
  logic [INDEX_ADDR_W-1:0] w_entry;

  assign w_accept = in_valid && (r_state == S_FILL);
  assign w_keep   = (SKIP_ZERO == 0) || (in_weight != '0);
  assign w_full   = (r_count == CNT_W'(IN_SIZE));

  // Packed entry: enable at the MSB, dst above src, any gap bits stay zero.
  always_comb begin
    w_entry                             = '0;
    w_entry[INDEX_ADDR_W-1]             = 1'b1;
    w_entry[2*PACK_BITS-1:PACK_BITS]    = in_dst;
    w_entry[PACK_BITS-1:0]              = in_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_weight   <= '0;
      r_index    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_addr     <= '0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (w_keep) begin
              if (w_full) begin
                r_overflow <= 1'b1;
              end else begin
                // Next free slot is the one whose linear index equals the fill count.
                for (int unsigned r = 0; r < N_ROWS; r++) begin
                  for (int unsigned c = 0; c < N_COLS; c++) begin
                    if (r_count == CNT_W'(r * N_COLS + c)) begin
                      r_index[r][c]  <= w_entry;
                      r_weight[r][c] <= in_weight;
                    end
                  end
                end
                r_count <= r_count + 1'b1;
              end
            end
            if (in_last) begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (frame_ready) begin
            r_weight   <= '0;
            r_index    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_addr     <= r_addr + 1'b1;
            r_state    <= S_FILL;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign in_ready       = (r_state == S_FILL);
  assign frame_valid    = (r_state == S_HOLD);
  assign weight_data    = r_weight;
  assign index_data     = r_index;
  assign frame_count    = r_count;
  assign frame_overflow = r_overflow;
  assign frame_addr     = r_addr;

endmodule

// File: tb/tb_sca_sparse_list_encoder.sv
module tb_sca_sparse_list_encoder;

  localparam int DATA_W   = 16;
  localparam int N_ROWS   = 4;
  localparam int N_COLS   = 4;
  localparam int IDX_W    = 10;
  localparam int ADDR_W   = 12;
  localparam int IN_SIZE  = N_ROWS * N_COLS;
  localparam int PB       = ((IDX_W - 1) / 2 > 1) ? (IDX_W - 1) / 2 : 1;
  localparam int CNT_W    = $clog2(IN_SIZE + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, frame_ready;
  logic [PB-1:0] in_src, in_dst;
  logic [DATA_W-1:0] in_weight;

  // dut_a drops zero weights, dut_b stores every entry; both share all inputs.
  logic a_in_ready, a_frame_valid, a_ovf, b_in_ready, b_frame_valid, b_ovf;
  logic [N_ROWS-1:0][N_COLS-1:0][DATA_W-1:0] a_wd, b_wd;
  logic [N_ROWS-1:0][N_COLS-1:0][IDX_W-1:0]  a_id, b_id;
  logic [CNT_W-1:0]  a_cnt, b_cnt;
  logic [ADDR_W-1:0] a_addr, b_addr;

  always #5 clk = ~clk;

  sca_sparse_list_encoder #(.SKIP_ZERO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_src(in_src), .in_dst(in_dst), .in_weight(in_weight), .in_last(in_last),
    .frame_valid(a_frame_valid), .frame_ready(frame_ready), .weight_data(a_wd),
    .index_data(a_id), .frame_count(a_cnt), .frame_overflow(a_ovf), .frame_addr(a_addr)
  );

  sca_sparse_list_encoder #(.SKIP_ZERO(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_src(in_src), .in_dst(in_dst), .in_weight(in_weight), .in_last(in_last),
    .frame_valid(b_frame_valid), .frame_ready(frame_ready), .weight_data(b_wd),
    .index_data(b_id), .frame_count(b_cnt), .frame_overflow(b_ovf), .frame_addr(b_addr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: per DUT, the list of kept entries plus frame flags.
  int m_src [2][IN_SIZE];
  int m_dst [2][IN_SIZE];
  int m_w   [2][IN_SIZE];
  int m_cnt [2];
  bit m_ovf [2];
  int m_addr[2];
  bit m_hold[2];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_ovf[d] = 0; m_addr[d] = 0; m_hold[d] = 0;
    end
  endfunction

  function automatic void model_accept(int s, int dd, int w, bit last);
    for (int d = 0; d < 2; d++) begin
      if (d == 1 || w != 0) begin
        if (m_cnt[d] < IN_SIZE) begin
          m_src[d][m_cnt[d]] = s; m_dst[d][m_cnt[d]] = dd; m_w[d][m_cnt[d]] = w;
          m_cnt[d]++;
        end else begin
          m_ovf[d] = 1;
        end
      end
      if (last) m_hold[d] = 1;
    end
  endfunction

  function automatic void model_release();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_ovf[d] = 0; m_hold[d] = 0;
      m_addr[d] = (m_addr[d] + 1) % (1 << ADDR_W);
    end
  endfunction

  task automatic check_all(string tag);
    logic [N_ROWS-1:0][N_COLS-1:0][DATA_W-1:0] wd;
    logic [N_ROWS-1:0][N_COLS-1:0][IDX_W-1:0]  id;
    logic rdy, fv, ov;
    logic [CNT_W-1:0] cn;
    logic [ADDR_W-1:0] ad;
    int k, exp_i, exp_w;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        wd = a_wd; id = a_id; rdy = a_in_ready; fv = a_frame_valid; ov = a_ovf; cn = a_cnt;
        ad = a_addr;
      end else begin
        wd = b_wd; id = b_id; rdy = b_in_ready; fv = b_frame_valid; ov = b_ovf; cn = b_cnt;
        ad = b_addr;
      end
      chk($sformatf("%s/d%0d/frame_valid", tag, d), 32'(fv), 32'(m_hold[d]));
      chk($sformatf("%s/d%0d/in_ready", tag, d), 32'(rdy), 32'(!m_hold[d]));
      chk($sformatf("%s/d%0d/frame_count", tag, d), 32'(cn), 32'(m_cnt[d]));
      chk($sformatf("%s/d%0d/frame_overflow", tag, d), 32'(ov), 32'(m_ovf[d]));
      chk($sformatf("%s/d%0d/frame_addr", tag, d), 32'(ad), 32'(m_addr[d]));
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLS; c++) begin
          k = r * N_COLS + c;
          if (k < m_cnt[d]) begin
            exp_i = (1 << (IDX_W - 1)) + m_dst[d][k] * (1 << PB) + m_src[d][k];
            exp_w = m_w[d][k] & ((1 << DATA_W) - 1);
          end else begin
            exp_i = 0; exp_w = 0;
          end
          chk($sformatf("%s/d%0d/index[%0d]", tag, d, k), 32'(id[r][c]), 32'(exp_i));
          chk($sformatf("%s/d%0d/weight[%0d]", tag, d, k), 32'(wd[r][c]), 32'(exp_w));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int s, int d, int w, bit last);
    int n = 0;
    in_valid = 1'b1; in_src = PB'(s); in_dst = PB'(d); in_weight = DATA_W'(w); in_last = last;
    while (!a_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!a_in_ready) begin
      chk("send_timeout_in_ready", 32'(a_in_ready), 32'd1);
    end else begin
      model_accept(s, d, w, last);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_frame();
    int n = 0;
    frame_ready = 1'b1;
    while (!a_frame_valid && n < 50) begin
      tick();
      n++;
    end
    if (!a_frame_valid) begin
      chk("release_timeout_frame_valid", 32'(a_frame_valid), 32'd1);
    end else begin
      model_release();
      tick();
    end
    frame_ready = 1'b0;
  endtask

  typedef struct {
    int src; int dst; int w; bit last; int exp_cnt; bit exp_valid;
  } vec_t;

  vec_t tbl[3];

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{src: 1, dst: 2, w: 5,  last: 1'b0, exp_cnt: 1, exp_valid: 1'b0};
    tbl[1] = '{src: 3, dst: 0, w: 0,  last: 1'b0, exp_cnt: 1, exp_valid: 1'b0};
    tbl[2] = '{src: 4, dst: 4, w: -7, last: 1'b1, exp_cnt: 2, exp_valid: 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; frame_ready = 1'b0;
    in_src = '0; in_dst = '0; in_weight = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("after_reset");

    // Basic frame from a vector table.
    for (int i = 0; i < 3; i++) begin
      send(tbl[i].src, tbl[i].dst, tbl[i].w, tbl[i].last);
      chk($sformatf("t1_cnt_%0d", i), 32'(a_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("t1_valid_%0d", i), 32'(a_frame_valid), 32'(tbl[i].exp_valid));
    end
    chk("t1_index00", 32'(a_id[0][0]), 32'h221);
    chk("t1_weight00", 32'(a_wd[0][0]), 32'h0005);
    chk("t1_index01", 32'(a_id[0][1]), 32'h244);
    chk("t1_weight01", 32'(a_wd[0][1]), 32'hfff9);
    chk("t1_addr", 32'(a_addr), 32'd0);
    check_all("t1_frame");
    release_frame();
    check_all("t1_released");

    // Overflow: 20 nonzero entries into 16 slots.
    for (int i = 0; i < 20; i++) send(i % 16, (i + 3) % 16, i + 1, i == 19);
    chk("t2_cnt", 32'(a_cnt), 32'd16);
    chk("t2_ovf", 32'(a_ovf), 32'd1);
    check_all("t2_frame");

    // Hold with in_valid asserted: nothing accepted, outputs frozen.
    in_valid = 1'b1; in_src = 4'd9; in_dst = 4'd9; in_weight = 16'd99; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_in_ready_%0d", i), 32'(a_in_ready), 32'd0);
      check_all("t3_hold");
    end
    in_valid = 1'b0; in_last = 1'b0;
    release_frame();
    chk("t3_in_ready_after", 32'(a_in_ready), 32'd1);
    check_all("t3_released");

    send(2, 3, 4, 1'b1);
    chk("t2_next_ovf", 32'(a_ovf), 32'd0);
    check_all("t2_next_frame");
    release_frame();

    // Single zero-weight entry: dropped by dut_a, stored by dut_b.
    send(0, 0, 0, 1'b1);
    chk("t4_a_cnt", 32'(a_cnt), 32'd0);
    chk("t4_b_cnt", 32'(b_cnt), 32'd1);
    chk("t4_b_index0", 32'(b_id[0][0]), 32'h200);
    check_all("t4_frame");
    release_frame();

    // Async reset mid-frame.
    send(1, 1, 1, 1'b0);
    send(2, 2, 2, 1'b0);
    send(3, 3, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t5_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(5, 6, 7, 1'b1);
    chk("t5_cnt", 32'(a_cnt), 32'd1);
    chk("t5_addr", 32'(a_addr), 32'd0);
    check_all("t5_frame");
    release_frame();

    // Randomized frames with idle gaps and delayed frame_ready.
    for (int f = 0; f < 30; f++) begin
      int n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++) begin
        int w = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 65535)) - 32768;
        repeat ($urandom_range(0, 2)) tick();
        send($urandom_range(0, 15), $urandom_range(0, 15), w, i == n - 1);
      end
      check_all($sformatf("rand_frame_%0d", f));
      repeat ($urandom_range(0, 3)) tick();
      check_all($sformatf("rand_hold_%0d", f));
      release_frame();
      check_all($sformatf("rand_released_%0d", f));
    end

    // Empty frames until the address counter wraps.
    model_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int f = 0; f < 4096; f++) begin
      send(0, 0, 0, 1'b1);
      if (f == 4095) begin
        chk("t6_addr_max", 32'(a_addr), 32'd4095);
        check_all("t6_last");
      end
      release_frame();
    end
    chk("t6_addr_wrap", 32'(a_addr), 32'd0);
    check_all("t6_wrapped");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
